// File: rtl/sram_responder.sv
// sram_responder: clocked 256Kx16 async SRAM pin model with byte lanes and programmable read latency
// Array is never reset so contents survive rst; only the read FSM and pin drive are cleared.
module sram_responder #(
  parameter int READ_LAT = 2,
  parameter int MEM_AW   = 16
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  output logic        access_err
);
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(READ_LAT - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;
  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [MEM_AW-1:0] r_rd_addr, w_rd_addr;
  logic [15:0]       r_rd_data, w_rd_data;
  logic              r_drive_en, w_drive_en;
  logic              r_access_err;
  logic [15:0]       r_mem [2**MEM_AW];
  logic [MEM_AW-1:0] w_a;
  logic [15:0]       w_mem;
  logic              w_wr, w_rq, w_unused;
  assign w_a      = SRAM_ADDR[MEM_AW-1:0];
  assign w_unused = ^SRAM_ADDR[17:MEM_AW];
  assign w_wr     = !SRAM_CE_N && !SRAM_WE_N;
  assign w_rq     = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign w_mem    = r_mem[w_a];
  assign access_err = r_access_err;
  // Pins gated combinationally so they release in the very cycle the request drops
  assign SRAM_DQ[15:8] = (r_drive_en && w_rq && !SRAM_UB_N) ? r_rd_data[15:8] : 8'bz;
  assign SRAM_DQ[7:0]  = (r_drive_en && w_rq && !SRAM_LB_N) ? r_rd_data[7:0]  : 8'bz;
  always_ff @(posedge clk) begin
    if (w_wr && !SRAM_UB_N) r_mem[w_a][15:8] <= SRAM_DQ[15:8];
    if (w_wr && !SRAM_LB_N) r_mem[w_a][7:0]  <= SRAM_DQ[7:0];
  end
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_rd_addr  = r_rd_addr;
    w_rd_data  = r_rd_data;
    w_drive_en = r_drive_en;
    if (w_wr || !w_rq) begin
      w_state    = S_IDLE;
      w_drive_en = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_rd_addr = w_a;
          if (READ_LAT == 1) begin
            w_rd_data  = w_mem;
            w_drive_en = 1'b1;
            w_state    = S_DRIVE;
          end else begin
            w_cnt   = LOAD;
            w_state = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_a != r_rd_addr) begin
            w_rd_addr = w_a;
            w_cnt     = LOAD;
          end else if (r_cnt == CW'(1)) begin
            w_rd_data  = w_mem;
            w_drive_en = 1'b1;
            w_state    = S_DRIVE;
          end else begin
            w_cnt = r_cnt - CW'(1);
          end
        end
        S_DRIVE: begin
          if (w_a != r_rd_addr && READ_LAT != 1) begin
            w_rd_addr  = w_a;
            w_drive_en = 1'b0;
            w_cnt      = LOAD;
            w_state    = S_WAIT;
          end else begin
            w_rd_addr = w_a;
            w_rd_data = w_mem;
          end
        end
        default: begin
          w_state    = S_IDLE;
          w_drive_en = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_drive_en   <= 1'b0;
      r_access_err <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_rd_addr    <= w_rd_addr;
      r_rd_data    <= w_rd_data;
      r_drive_en   <= w_drive_en;
      r_access_err <= w_wr && !SRAM_OE_N;
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed SRAM pin sequences; expectations queued per cycle and checked by a monitor
// The bus has pull-ups, so a released lane reads back as all ones.
module tb_sram_responder;
  logic        clk, rst, we_n, ce_n, oe_n, ub_n, lb_n, tb_drv, err;
  logic [17:0] addr;
  logic [15:0] tb_dq;
  tri1  [15:0] dq;
  int          cyc, passed, total;
  typedef struct {int c; logic [15:0] d; logic e; string n;} exp_t;
  exp_t q[$];
  assign dq = tb_drv ? tb_dq : 16'hz;
  sram_responder #(.READ_LAT(2), .MEM_AW(16)) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .access_err(err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    passed = 0;
    total  = 0;
  end
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].c < cyc) begin
      total++;
      $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", q[0].n, q[0].c, cyc);
      void'(q.pop_front());
    end
    if (q.size() != 0 && q[0].c == cyc) begin
      total++;
      if (dq === q[0].d && err === q[0].e) passed++;
      else $display("FAIL %s: dq=%h err=%b, required dq=%h err=%b", q[0].n, dq, err, q[0].d, q[0].e);
      void'(q.pop_front());
    end
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic pins(input logic [17:0] a, input logic ce, we, oe, ub, lb, drv, input logic [15:0] d);
    addr = a; ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb; tb_drv = drv; tb_dq = d;
  endtask
  task automatic expect_now(input logic [15:0] d, input logic e, input string n);
    q.push_back('{cyc, d, e, n});
  endtask
  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, lb);
    nxt();
    pins(a, 0, 0, 1, ub, lb, 1, d);
  endtask
  task automatic rd(input logic [17:0] a, input logic ub, lb, input logic [15:0] d, input string n);
    nxt();
    pins(a, 0, 1, 0, ub, lb, 0, 16'h0);
    expect_now(d, 1'b0, n);
  endtask
  task automatic idle(input logic e, input string n);
    nxt();
    pins(18'h0, 1, 1, 1, 1, 1, 0, 16'h0);
    expect_now(16'hFFFF, e, n);
  endtask
  initial begin
    rst = 0;
    pins(18'h0, 1, 1, 1, 1, 1, 0, 16'h0);
    nxt();
    expect_now(16'hFFFF, 1'b0, "reset_state");
    nxt();
    rst = 1;
    wr(18'd5, 16'hBEEF, 0, 0);
    rd(18'd5, 0, 0, 16'hFFFF, "t1_lat0");
    rd(18'd5, 0, 0, 16'hFFFF, "t1_lat1");
    rd(18'd5, 0, 0, 16'hBEEF, "t1_data0");
    rd(18'd5, 0, 0, 16'hBEEF, "t1_data1");
    idle(1'b0, "t1_ce_release");
    wr(18'd7, 16'h1234, 0, 0);
    wr(18'd7, 16'hAB00, 0, 1);
    rd(18'd7, 0, 0, 16'hFFFF, "t2_lat0");
    rd(18'd7, 0, 0, 16'hFFFF, "t2_lat1");
    rd(18'd7, 0, 0, 16'hAB34, "t2_byte_merge");
    rd(18'd7, 0, 1, 16'hABFF, "t2_lb_off");
    rd(18'd7, 0, 0, 16'hAB34, "t2_lb_on");
    rd(18'd5, 0, 0, 16'hAB34, "t4_addr_change");
    rd(18'd5, 0, 0, 16'hFFFF, "t4_gap");
    rd(18'd5, 0, 0, 16'hBEEF, "t4_new_addr");
    nxt();
    pins(18'd5, 0, 1, 1, 0, 0, 0, 16'h0);
    expect_now(16'hFFFF, 1'b0, "t4_oe_release");
    wr(18'h10003, 16'h0F0F, 0, 0);
    rd(18'd3, 0, 0, 16'hFFFF, "t3_lat0");
    rd(18'h20003, 0, 0, 16'hFFFF, "t3_alias_lat1");
    rd(18'd3, 0, 0, 16'h0F0F, "t3_alias_data");
    nxt();
    pins(18'd9, 0, 0, 0, 0, 0, 1, 16'h5555);
    expect_now(16'h5555, 1'b0, "t5_overlap");
    idle(1'b1, "t5_err_pulse");
    idle(1'b0, "t5_err_end");
    rd(18'd9, 0, 0, 16'hFFFF, "t5_lat0");
    rd(18'd9, 0, 0, 16'hFFFF, "t5_lat1");
    rd(18'd9, 0, 0, 16'h5555, "t5_written");
    nxt();
    pins(18'd9, 0, 0, 0, 0, 0, 0, 16'h0);
    expect_now(16'hFFFF, 1'b0, "t5_we_release");
    idle(1'b1, "t5_err_pulse2");
    rd(18'd5, 0, 0, 16'hFFFF, "t6_lat0");
    rd(18'd5, 0, 0, 16'hFFFF, "t6_lat1");
    rd(18'd5, 0, 0, 16'hBEEF, "t6_driving");
    nxt();
    rst = 0;
    expect_now(16'hFFFF, 1'b0, "t6_async_release");
    nxt();
    rst = 1;
    expect_now(16'hFFFF, 1'b0, "t6_post_lat0");
    rd(18'd5, 0, 0, 16'hFFFF, "t6_post_lat1");
    rd(18'd5, 0, 0, 16'hBEEF, "t6_persist");
    idle(1'b0, "final_idle");
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      total += q.size();
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
